// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// bubble bit positions and the reset redirect address.
package pipe_hold_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int BUB_IFID = 0;
  localparam int BUB_IDEX = 1;

  localparam logic [63:0] RESET_ADDR = 64'd0;

  // Width of the flush counter; FLUSH_CYC is limited to 1..7.
  localparam int FCNT_W = 3;

  // A bus stall starves fetch, so IF/ID takes the bubble. A divider stall
  // holds EX, so ID/EX takes it. The bus cause wins when both are present.
  function automatic logic [1:0] stall_bubble(input logic bus, input logic div);
    logic [1:0] b;
    b = 2'b00;
    if (bus) begin
      b[BUB_IFID] = 1'b1;
    end else if (div) begin
      b[BUB_IDEX] = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [1:0] flush_bubble();
    logic [1:0] b;
    b           = 2'b00;
    b[BUB_IFID] = 1'b1;
    b[BUB_IDEX] = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/pipe_hold_ctrl_stall_wdt.sv
// Stall watchdog: saturating count of consecutive stall cycles with a
// single tmo pulse when the count first reaches its all-ones value.
module stall_wdt #(
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  output logic tmo_o
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  // stall_i reflects the state of the cycle being entered, so cnt_q equals
  // the 1-based index of the current stall cycle.
  always_comb begin
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    if (!stall_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      tmo_d = (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign tmo_o = tmo_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline sequencing controller: arbitrates redirects and stalls, drives
// PC hold / bubble insertion and the registered redirect target.
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int AW        = 32,
  parameter int FLUSH_CYC = 2,
  parameter int TMO_W     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          int_req_i,
  input  logic [AW-1:0] int_addr_i,
  input  logic          jump_req_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          bus_hold_i,
  input  logic          div_busy_i,
  output logic          redirect_o,
  output logic [AW-1:0] redirect_addr_o,
  output logic          pc_hold_o,
  output logic [1:0]    bubble_o,
  output logic          tmo_o
);

  state_e            state_q, state_d;
  logic              redirect_q, redirect_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              pc_hold_q, pc_hold_d;
  logic [1:0]        bubble_q, bubble_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              settle;

  // Outside FLUSH, or in the last flush cycle, the next state depends only
  // on the stall causes.
  assign settle = (state_q != ST_FLUSH) || (fcnt_q <= FCNT_W'(1));

  always_comb begin
    state_d    = state_q;
    redirect_d = 1'b0;
    addr_d     = addr_q;
    pc_hold_d  = 1'b0;
    bubble_d   = 2'b00;
    fcnt_d     = fcnt_q;
    if (int_req_i || jump_req_i) begin
      // Interrupt beats a simultaneous jump; the jump's EX slot is flushed.
      state_d    = ST_FLUSH;
      redirect_d = 1'b1;
      addr_d     = int_req_i ? int_addr_i : jump_addr_i;
      fcnt_d     = FCNT_W'(FLUSH_CYC);
      bubble_d   = flush_bubble();
    end else if (settle) begin
      fcnt_d = '0;
      if (bus_hold_i || div_busy_i) begin
        state_d   = ST_STALL;
        pc_hold_d = 1'b1;
        bubble_d  = stall_bubble(bus_hold_i, div_busy_i);
      end else begin
        state_d = ST_RUN;
      end
    end else begin
      // Bus hold freezes the flush count and holds the PC at the new target.
      state_d   = ST_FLUSH;
      pc_hold_d = bus_hold_i;
      bubble_d  = flush_bubble();
      if (!bus_hold_i) begin
        fcnt_d = fcnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      redirect_q <= 1'b0;
      addr_q     <= AW'(RESET_ADDR);
      pc_hold_q  <= 1'b0;
      bubble_q   <= 2'b00;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
      addr_q     <= addr_d;
      pc_hold_q  <= pc_hold_d;
      bubble_q   <= bubble_d;
      fcnt_q     <= fcnt_d;
    end
  end

  stall_wdt #(
    .TMO_W(TMO_W)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .stall_i(state_d == ST_STALL),
    .tmo_o  (tmo_o)
  );

  assign redirect_o      = redirect_q;
  assign redirect_addr_o = addr_q;
  assign pc_hold_o       = pc_hold_q;
  assign bubble_o        = bubble_q;

endmodule
